// File: rtl/vex_dbus_responder.sv
// vex_dbus_responder
//   Responder for a VexRiscv-style dBus. It accepts commands under the
//   control of a free stall request, queues reads in a small FIFO, and
//   answers them in order. A response may be delayed by a free stall
//   request, but only for a bounded number of cycles. Protocol violations
//   by the core are recorded in a sticky flag.
//
// Parameters
//   DEPTH       outstanding read capacity (power of two, 2..16)
//   MAX_STALL   longest run of stall cycles on either channel (1..7)
//
// Ports
//   clock, resetn            clock; asynchronous active-low reset
//   cmd_valid/wr/address/size  core command channel
//   cmd_ready                command accepted this cycle (combinational)
//   cmd_stall_req            free request to stall the command channel
//   rsp_stall_req            free request to delay the head response
//   rsp_data_in              free value returned as read data
//   rsp_ready/data/address   single-cycle read response
//   pending                  number of outstanding reads
//   protocol_err             sticky protocol violation flag
module vex_dbus_responder #(
    parameter int DEPTH     = 4,
    parameter int MAX_STALL = 3
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        cmd_valid,
    input  logic        cmd_wr,
    input  logic [31:0] cmd_address,
    input  logic [1:0]  cmd_size,
    output logic        cmd_ready,
    input  logic        cmd_stall_req,
    input  logic        rsp_stall_req,
    input  logic [31:0] rsp_data_in,
    output logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [31:0] rsp_address,
    output logic [4:0]  pending,
    output logic        protocol_err
);

    localparam int          PTR_W       = $clog2(DEPTH);
    localparam logic [2:0]  MAX_STALL_C = 3'(MAX_STALL);
    localparam logic [4:0]  DEPTH_C     = 5'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FORCE = 2'd2
    } head_state_t;

    head_state_t      state_q, state_d;
    logic [2:0]       age_q, age_d;
    logic [2:0]       cmd_stall_cnt_q, cmd_stall_cnt_d;
    logic [4:0]       count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             stalled_q, stalled_d;
    logic [31:0]      hold_address_q, hold_address_d;
    logic             hold_wr_q, hold_wr_d;
    logic [1:0]       hold_size_q, hold_size_d;
    logic             protocol_err_q, protocol_err_d;

    // Each FIFO entry holds {address, size} of one accepted read.
    logic [33:0]      entry_mem_q [DEPTH];

    logic             full;
    logic             accept;
    logic             push;
    logic             pop;
    logic             changed_while_stalled;
    logic             bad_size;
    logic             misaligned;
    logic [33:0]      head_entry;

    // Command channel. Gating with resetn keeps cmd_ready low during reset
    // even though the FIFO then looks empty.
    always_comb begin
        full      = (count_q == DEPTH_C);
        cmd_ready = resetn && !full &&
                    (!cmd_stall_req || (cmd_stall_cnt_q == MAX_STALL_C));
        accept    = cmd_valid && cmd_ready;
        push      = accept && !cmd_wr;

        cmd_stall_cnt_d = cmd_stall_cnt_q;
        if (!cmd_valid || accept) begin
            cmd_stall_cnt_d = 3'd0;
        end else if (cmd_stall_cnt_q < MAX_STALL_C) begin
            cmd_stall_cnt_d = cmd_stall_cnt_q + 3'd1;
        end
    end

    // Head state machine. The state for the next cycle is derived from the
    // next occupancy and age, so a freshly pushed entry is only visible as
    // head one cycle later, which gives the minimum latency of one cycle.
    always_comb begin
        rsp_ready  = 1'b0;
        head_entry = entry_mem_q[rd_ptr_q];

        case (state_q)
            IDLE:    rsp_ready = 1'b0;
            WAIT:    rsp_ready = !rsp_stall_req;
            FORCE:   rsp_ready = 1'b1;
            default: rsp_ready = 1'b0;
        endcase

        pop = rsp_ready;

        age_d = age_q;
        if ((state_q == IDLE) || pop) begin
            age_d = 3'd0;
        end else if (age_q < MAX_STALL_C) begin
            age_d = age_q + 3'd1;
        end

        count_d  = count_q + {4'd0, push} - {4'd0, pop};
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

        state_d = WAIT;
        if (count_d == 5'd0) begin
            state_d = IDLE;
        end else if (age_d == MAX_STALL_C) begin
            state_d = FORCE;
        end

        rsp_address = rsp_ready ? head_entry[33:2] : 32'd0;
        rsp_data    = rsp_ready ? rsp_data_in      : 32'd0;
    end

    // Protocol checking. A stalled command must be held unchanged until it
    // is accepted; size 3 and misaligned accesses are always violations.
    always_comb begin
        stalled_d      = cmd_valid && !cmd_ready;
        hold_address_d = cmd_address;
        hold_wr_d      = cmd_wr;
        hold_size_d    = cmd_size;

        changed_while_stalled = stalled_q &&
                                (!cmd_valid ||
                                 (cmd_address != hold_address_q) ||
                                 (cmd_wr      != hold_wr_q) ||
                                 (cmd_size    != hold_size_q));
        bad_size   = cmd_valid && (cmd_size == 2'd3);
        misaligned = cmd_valid &&
                     (((cmd_size == 2'd1) && cmd_address[0]) ||
                      ((cmd_size == 2'd2) && (cmd_address[1:0] != 2'd0)));

        protocol_err_d = protocol_err_q || changed_while_stalled ||
                         bad_size || misaligned;
    end

    assign pending      = count_q;
    assign protocol_err = protocol_err_q;

    // Control state; reset discards every outstanding read.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q         <= IDLE;
            age_q           <= 3'd0;
            cmd_stall_cnt_q <= 3'd0;
            count_q         <= 5'd0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            stalled_q       <= 1'b0;
            hold_address_q  <= 32'd0;
            hold_wr_q       <= 1'b0;
            hold_size_q     <= 2'd0;
            protocol_err_q  <= 1'b0;
        end else begin
            state_q         <= state_d;
            age_q           <= age_d;
            cmd_stall_cnt_q <= cmd_stall_cnt_d;
            count_q         <= count_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            stalled_q       <= stalled_d;
            hold_address_q  <= hold_address_d;
            hold_wr_q       <= hold_wr_d;
            hold_size_q     <= hold_size_d;
            protocol_err_q  <= protocol_err_d;
        end
    end

    // FIFO storage needs no reset: entries are only read when count_q says
    // they are valid.
    always_ff @(posedge clock) begin
        if (push) begin
            entry_mem_q[wr_ptr_q] <= {cmd_address, cmd_size};
        end
    end

endmodule

// File: tb/tb_vex_dbus_responder.sv
// Directed testbench for vex_dbus_responder with default parameters
// (DEPTH=4, MAX_STALL=3). Inputs change on the falling edge and outputs
// are sampled 2 time units later, well before the next rising edge.
module tb_vex_dbus_responder;

    logic        clock;
    logic        resetn;
    logic        cmd_valid;
    logic        cmd_wr;
    logic [31:0] cmd_address;
    logic [1:0]  cmd_size;
    logic        cmd_ready;
    logic        cmd_stall_req;
    logic        rsp_stall_req;
    logic [31:0] rsp_data_in;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [31:0] rsp_address;
    logic [4:0]  pending;
    logic        protocol_err;

    int vectorCount = 0;
    int missCount   = 0;

    vex_dbus_responder #(.DEPTH(4), .MAX_STALL(3)) dut (
        .clock         (clock),
        .resetn        (resetn),
        .cmd_valid     (cmd_valid),
        .cmd_wr        (cmd_wr),
        .cmd_address   (cmd_address),
        .cmd_size      (cmd_size),
        .cmd_ready     (cmd_ready),
        .cmd_stall_req (cmd_stall_req),
        .rsp_stall_req (rsp_stall_req),
        .rsp_data_in   (rsp_data_in),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_address   (rsp_address),
        .pending       (pending),
        .protocol_err  (protocol_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive one cycle's worth of inputs.
    task automatic applyStimulus(input logic v, input logic w,
                                 input logic [31:0] a, input logic [1:0] s,
                                 input logic cs, input logic rs,
                                 input logic [31:0] d);
        cmd_valid     = v;
        cmd_wr        = w;
        cmd_address   = a;
        cmd_size      = s;
        cmd_stall_req = cs;
        rsp_stall_req = rs;
        rsp_data_in   = d;
    endtask

    // Count one comparison and report it if it misses.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h",
                     tag, observed, expected);
        end
    endtask

    initial begin
        logic        expReady;
        logic [31:0] expAddr;

        resetn = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 2'd2, 1'b0, 1'b0, 32'h0);

        // Reset values.
        @(negedge clock); #2;
        checkOutput("reset cmd_ready",    {31'd0, cmd_ready},    32'd0);
        checkOutput("reset rsp_ready",    {31'd0, rsp_ready},    32'd0);
        checkOutput("reset rsp_data",     rsp_data,              32'd0);
        checkOutput("reset rsp_address",  rsp_address,           32'd0);
        checkOutput("reset pending",      {27'd0, pending},      32'd0);
        checkOutput("reset protocol_err", {31'd0, protocol_err}, 32'd0);
        @(negedge clock);
        resetn = 1'b1;

        // Unstalled read to 0x100: accepted now, answered next cycle.
        applyStimulus(1'b1, 1'b0, 32'h100, 2'd2, 1'b0, 1'b0, 32'h0);
        #2;
        checkOutput("rd100 cmd_ready", {31'd0, cmd_ready}, 32'd1);
        checkOutput("rd100 rsp early", {31'd0, rsp_ready}, 32'd0);
        @(negedge clock);
        applyStimulus(1'b0, 1'b0, 32'h0, 2'd2, 1'b0, 1'b0, 32'hDEADBEEF);
        #2;
        checkOutput("rd100 rsp_ready",   {31'd0, rsp_ready}, 32'd1);
        checkOutput("rd100 rsp_address", rsp_address,        32'h100);
        checkOutput("rd100 rsp_data",    rsp_data,           32'hDEADBEEF);
        checkOutput("rd100 pending",     {27'd0, pending},   32'd1);
        @(negedge clock);
        applyStimulus(1'b0, 1'b0, 32'h0, 2'd2, 1'b0, 1'b0, 32'hDEADBEEF);
        #2;
        checkOutput("rd100 done rsp_ready", {31'd0, rsp_ready}, 32'd0);
        checkOutput("rd100 done rsp_data",  rsp_data,           32'd0);
        checkOutput("rd100 done pending",   {27'd0, pending},   32'd0);
        @(negedge clock);

        // Command stall held: three stalled cycles, accepted on the fourth.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1, 32'h40, 2'd2, 1'b1, 1'b0, 32'h0);
            #2;
            checkOutput($sformatf("cmdstall cyc%0d", i), {31'd0, cmd_ready},
                        (i == 3) ? 32'd1 : 32'd0);
            @(negedge clock);
        end

        // Write to 0x200: accepted, never answered.
        applyStimulus(1'b1, 1'b1, 32'h200, 2'd2, 1'b0, 1'b0, 32'h0);
        #2;
        checkOutput("wr200 cmd_ready", {31'd0, cmd_ready}, 32'd1);
        @(negedge clock);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 2'd2, 1'b0, 1'b0, 32'h77);
            #2;
            checkOutput($sformatf("wr200 rsp cyc%0d", i), {31'd0, rsp_ready}, 32'd0);
            checkOutput($sformatf("wr200 pending cyc%0d", i), {27'd0, pending}, 32'd0);
            @(negedge clock);
        end
        checkOutput("no err after clean traffic", {31'd0, protocol_err}, 32'd0);

        // Four reads with the response stalled: the FIFO fills, then each
        // head is forced out once it has waited MAX_STALL cycles. Age
        // restarts on every pop, so forced responses are 4 cycles apart.
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 1'b0, 32'h300 + 32'(4 * k), 2'd2, 1'b0, 1'b1,
                          32'h5A000000 | 32'(k));
            #2;
            checkOutput($sformatf("fill%0d cmd_ready", k), {31'd0, cmd_ready}, 32'd1);
            checkOutput($sformatf("fill%0d rsp_ready", k), {31'd0, rsp_ready}, 32'd0);
            @(negedge clock);
        end
        for (int k = 4; k < 18; k++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 2'd2, 1'b0, 1'b1, 32'h5A000000 | 32'(k));
            #2;
            if (k == 4) begin
                checkOutput("full cmd_ready", {31'd0, cmd_ready}, 32'd0);
            end
            expReady = (k <= 16) && (((k - 4) % 4) == 0);
            expAddr  = expReady ? 32'h300 + 32'(4 * ((k - 4) / 4)) : 32'd0;
            checkOutput($sformatf("drain%0d rsp_ready", k), {31'd0, rsp_ready},
                        {31'd0, expReady});
            checkOutput($sformatf("drain%0d rsp_address", k), rsp_address, expAddr);
            checkOutput($sformatf("drain%0d rsp_data", k), rsp_data,
                        expReady ? (32'h5A000000 | 32'(k)) : 32'd0);
            checkOutput($sformatf("drain%0d pending", k), {27'd0, pending},
                        32'(4 - ((k - 1) / 4)));
            @(negedge clock);
        end

        // Address changed from 0x10 to 0x14 while stalled.
        applyStimulus(1'b1, 1'b0, 32'h10, 2'd2, 1'b1, 1'b0, 32'h0);
        #2;
        checkOutput("chg cmd_ready", {31'd0, cmd_ready}, 32'd0);
        checkOutput("chg err before", {31'd0, protocol_err}, 32'd0);
        @(negedge clock);
        applyStimulus(1'b1, 1'b0, 32'h14, 2'd2, 1'b1, 1'b0, 32'h0);
        #2;
        checkOutput("chg err same cycle", {31'd0, protocol_err}, 32'd0);
        @(negedge clock);
        applyStimulus(1'b0, 1'b0, 32'h0, 2'd2, 1'b0, 1'b0, 32'h0);
        #2;
        checkOutput("chg err set", {31'd0, protocol_err}, 32'd1);
        @(negedge clock);
        #2;
        checkOutput("chg err sticky", {31'd0, protocol_err}, 32'd1);
        resetn = 1'b0;
        #1;
        checkOutput("err cleared by reset", {31'd0, protocol_err}, 32'd0);
        @(negedge clock);
        resetn = 1'b1;

        // Misaligned word read to 0x102.
        applyStimulus(1'b1, 1'b0, 32'h102, 2'd2, 1'b0, 1'b0, 32'h0);
        #2;
        checkOutput("mis cmd_ready", {31'd0, cmd_ready}, 32'd1);
        checkOutput("mis err before", {31'd0, protocol_err}, 32'd0);
        @(negedge clock);
        applyStimulus(1'b0, 1'b0, 32'h0, 2'd2, 1'b0, 1'b0, 32'h12345678);
        #2;
        checkOutput("mis err set", {31'd0, protocol_err}, 32'd1);
        checkOutput("mis rsp_address", rsp_address, 32'h102);
        @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            #2;
            checkOutput($sformatf("mis err sticky%0d", i), {31'd0, protocol_err}, 32'd1);
            @(negedge clock);
        end

        // Reset with two reads outstanding.
        applyStimulus(1'b1, 1'b0, 32'h400, 2'd2, 1'b0, 1'b1, 32'h0);
        #2;
        checkOutput("rst rd0 cmd_ready", {31'd0, cmd_ready}, 32'd1);
        @(negedge clock);
        applyStimulus(1'b1, 1'b0, 32'h404, 2'd2, 1'b0, 1'b1, 32'h0);
        @(negedge clock);
        applyStimulus(1'b0, 1'b0, 32'h0, 2'd2, 1'b0, 1'b1, 32'hCAFE0000);
        #2;
        checkOutput("rst pending before", {27'd0, pending}, 32'd2);
        checkOutput("rst rsp before", {31'd0, rsp_ready}, 32'd0);
        #1 resetn = 1'b0;
        #1;
        checkOutput("rst pending", {27'd0, pending}, 32'd0);
        checkOutput("rst cmd_ready", {31'd0, cmd_ready}, 32'd0);
        checkOutput("rst rsp_ready", {31'd0, rsp_ready}, 32'd0);
        @(negedge clock);
        @(negedge clock);
        resetn = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0, 2'd2, 1'b0, 1'b0, 32'hCAFE0001);
        for (int i = 0; i < 6; i++) begin
            #2;
            checkOutput($sformatf("post-rst rsp cyc%0d", i), {31'd0, rsp_ready}, 32'd0);
            checkOutput($sformatf("post-rst pending cyc%0d", i), {27'd0, pending}, 32'd0);
            @(negedge clock);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
